// File: rtl/fpu_request_arbiter.sv
// fpu_request_arbiter: round-robin sharing of one half-precision FPU among N_REQ requesters.
// Ports: clk/rst (sync, active-high); req_valid/req_a/req_b/req_op in, req_ready one-hot accept pulse out;
// rsp_valid/rsp_result/rsp_error out with rsp_ready in; fpu_start/fpu_a/fpu_b/fpu_op out to the FPU,
// fpu_done/fpu_error/fpu_result back; busy and grant_id status out.
module fpu_request_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [16*N_REQ-1:0]        req_a,
  input  logic [16*N_REQ-1:0]        req_b,
  input  logic [2*N_REQ-1:0]         req_op,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [15:0]                rsp_result,
  output logic                       rsp_error,
  output logic                       fpu_start,
  output logic [17:0]                fpu_a,
  output logic [17:0]                fpu_b,
  output logic [1:0]                 fpu_op,
  input  logic                       fpu_done,
  input  logic                       fpu_error,
  input  logic [15:0]                fpu_result,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            r_state;
  logic [GW-1:0]     r_ptr, r_g;
  logic [CW-1:0]     r_cnt;
  logic [N_REQ-1:0]  r_req_ready, r_rsp_valid;
  logic [15:0]       r_rsp_result;
  logic              r_rsp_error, r_fpu_start, r_busy;
  logic [17:0]       r_fpu_a, r_fpu_b;
  logic [1:0]        r_fpu_op;
  logic [GW-1:0]     w_gnt;
  logic              w_div0;
  function automatic logic [17:0] expand(logic [15:0] h);
    return {h[15], h[14:10], 1'b0, |h[14:10], h[9:0]};
  endfunction
  // Scan downward over offsets so the smallest offset from p that is set wins.
  function automatic logic [GW-1:0] pick(logic [N_REQ-1:0] v, logic [GW-1:0] p);
    pick = p;
    for (int k = N_REQ-1; k >= 0; k--)
      if (v[(int'(p) + k) % N_REQ]) pick = GW'((int'(p) + k) % N_REQ);
  endfunction
  assign w_gnt  = pick(req_valid, r_ptr);
  // The expanded divisor keeps the exponent in bits [16:12].
  assign w_div0 = r_fpu_op == 2'b11 && r_fpu_b[16:12] == 5'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_g          <= '0;
      r_cnt        <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_error  <= 1'b0;
      r_fpu_start  <= 1'b0;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_fpu_op     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_fpu_start <= 1'b0;
      case (r_state)
        IDLE: if (|req_valid) begin
          r_req_ready <= ONE << w_gnt;
          r_g         <= w_gnt;
          r_fpu_a     <= expand(req_a[16*w_gnt +: 16]);
          r_fpu_b     <= expand(req_b[16*w_gnt +: 16]);
          r_fpu_op    <= req_op[2*w_gnt +: 2];
          r_cnt       <= '0;
          r_busy      <= 1'b1;
          r_state     <= ISSUE;
        end
        // ISSUE spans two cycles (r_cnt 0 then 1) so the start pulse lands in the cycle after accept.
        ISSUE: if (r_cnt == '0) begin
          r_cnt       <= CW'(1);
          r_fpu_start <= !w_div0;
        end else begin
          r_cnt <= '0;
          if (w_div0) begin
            r_rsp_result <= 16'h7E00;
            r_rsp_error  <= 1'b1;
            r_rsp_valid  <= ONE << r_g;
            r_state      <= RESP;
          end else r_state <= WAIT;
        end
        WAIT: if (fpu_done) begin
          r_rsp_result <= fpu_result;
          r_rsp_error  <= fpu_error;
          r_rsp_valid  <= ONE << r_g;
          r_state      <= RESP;
        end else if (r_cnt == CW'(TIMEOUT-1)) begin
          r_rsp_result <= 16'h7E00;
          r_rsp_error  <= 1'b1;
          r_rsp_valid  <= ONE << r_g;
          r_state      <= RESP;
        end else r_cnt <= r_cnt + 1'b1;
        RESP: if (rsp_ready[r_g]) begin
          r_rsp_valid <= '0;
          r_ptr       <= (int'(r_g) == N_REQ-1) ? '0 : r_g + 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_error  = r_rsp_error;
  assign fpu_start  = r_fpu_start;
  assign fpu_a      = r_fpu_a;
  assign fpu_b      = r_fpu_b;
  assign fpu_op     = r_fpu_op;
  assign busy       = r_busy;
  assign grant_id   = r_g;
endmodule

// File: tb/tb_fpu_request_arbiter.sv
// tb_fpu_request_arbiter: directed table-driven bench for fpu_request_arbiter.
module tb_fpu_request_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [7:0]  req_op = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [15:0] rsp_result;
  logic        rsp_error, fpu_start, busy;
  logic [17:0] fpu_a, fpu_b;
  logic [1:0]  fpu_op, grant_id;
  logic        fpu_done = 1'b0, fpu_error = 1'b0;
  logic [15:0] fpu_result = '0;
  int checks = 0, errors = 0;
  fpu_request_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_done(fpu_done), .fpu_error(fpu_error), .fpu_result(fpu_result), .busy(busy), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  typedef struct {
    int r; logic [15:0] a, b; logic [1:0] op; int d; logic [15:0] fres; logic ferr;
    logic [15:0] eres; logic eerr; logic estart; int ecyc; logic [17:0] efa, efb; int hold;
  } vec_t;
  vec_t vecs[8];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic do_op(input vec_t v);
    int c, starts, rc;
    logic bad, bad2;
    logic [3:0] oh;
    logic [15:0] hr;
    logic he;
    oh = 4'b0001 << v.r;
    req_a[16*v.r +: 16] = v.a;
    req_b[16*v.r +: 16] = v.b;
    req_op[2*v.r +: 2]  = v.op;
    req_valid = oh;
    c = 0;
    do begin tick; c++; end while (req_ready == 4'b0 && c < 20);
    chk("accept", req_ready, oh);
    chk("grant_id", grant_id, v.r);
    req_valid = '0;
    starts = 0; rc = -1; bad = 1'b0;
    for (c = 1; c < 100 && rc < 0; c++) begin
      tick;
      fpu_done   = (v.d >= 0 && c == 2 + v.d);
      fpu_result = v.fres;
      fpu_error  = v.ferr;
      if (fpu_start) starts++;
      if (c == 1) chk("start_c1", fpu_start, v.estart);
      if (rsp_valid == 4'b0 && (fpu_a !== v.efa || fpu_b !== v.efb || fpu_op !== v.op)) bad = 1'b1;
      if (rsp_valid != 4'b0) rc = c;
    end
    fpu_done = 1'b0;
    chk("rsp_cycle", rc, v.ecyc);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_result", rsp_result, v.eres);
    chk("rsp_error", rsp_error, v.eerr);
    chk("start_count", starts, v.estart ? 1 : 0);
    chk("operands_stable", bad, 1'b0);
    hr = rsp_result; he = rsp_error; bad2 = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      req_valid = ~oh;
      rsp_ready = ~oh;
      tick;
      if (rsp_valid !== oh || rsp_result !== hr || rsp_error !== he || req_ready !== 4'b0) bad2 = 1'b1;
    end
    chk("resp_hold", bad2, 1'b0);
    req_valid = '0;
    rsp_ready = oh;
    tick;
    rsp_ready = '0;
    chk("rsp_drop", {rsp_valid, busy}, 5'b0);
  endtask
  initial begin
    logic [3:0] grants[5];
    int n, ps;
    vecs[0] = '{0, 16'h3C00, 16'h4000, 2'b00, 3,  16'h4200, 1'b0, 16'h4200, 1'b0, 1'b1, 6,  18'h0F400, 18'h10400, 0};
    vecs[1] = '{2, 16'h3C00, 16'h0000, 2'b11, -1, 16'h0000, 1'b0, 16'h7E00, 1'b1, 1'b0, 2,  18'h0F400, 18'h00000, 0};
    vecs[2] = '{1, 16'hC000, 16'h3800, 2'b10, 0,  16'hBC00, 1'b0, 16'hBC00, 1'b0, 1'b1, 3,  18'h30400, 18'h0E400, 10};
    vecs[3] = '{3, 16'h3C00, 16'h4000, 2'b11, 5,  16'h3800, 1'b0, 16'h3800, 1'b0, 1'b1, 8,  18'h0F400, 18'h10400, 0};
    vecs[4] = '{1, 16'h0001, 16'h0400, 2'b01, 1,  16'h0123, 1'b1, 16'h0123, 1'b1, 1'b1, 4,  18'h00001, 18'h01400, 0};
    vecs[5] = '{0, 16'h4000, 16'h8000, 2'b11, -1, 16'h0000, 1'b0, 16'h7E00, 1'b1, 1'b0, 2,  18'h10400, 18'h20000, 0};
    vecs[6] = '{2, 16'h3C00, 16'h3C00, 2'b00, -1, 16'h0000, 1'b0, 16'h7E00, 1'b1, 1'b1, 66, 18'h0F400, 18'h0F400, 0};
    vecs[7] = '{2, 16'h3C00, 16'h3C00, 2'b00, 63, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b1, 66, 18'h0F400, 18'h0F400, 0};
    tick; tick;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_error, fpu_start, fpu_a, fpu_b, fpu_op, busy, grant_id}, '0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) do_op(vecs[i]);
    req_a[48 +: 16] = 16'h3C00; req_b[48 +: 16] = 16'h4000; req_op[6 +: 2] = 2'b00;
    req_valid = 4'b1000;
    n = 0;
    do begin tick; n++; end while (req_ready == 4'b0 && n < 20);
    chk("mid_accept", req_ready, 4'b1000);
    req_valid = '0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_error, fpu_start, fpu_a, fpu_b, fpu_op, busy, grant_id}, '0);
    fpu_done = 1'b1; fpu_result = 16'h5555;
    tick;
    fpu_done = 1'b0;
    tick; tick;
    chk("late_done_ignored", {rsp_valid, busy, rsp_result}, '0);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    n = 0; ps = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      tick;
      fpu_done = ps[0];
      ps = int'(fpu_start);
      if (req_ready != 4'b0) begin
        grants[n] = req_ready;
        n++;
      end
    end
    req_valid = '0;
    for (int c = 0; c < 20 && busy; c++) begin
      tick;
      fpu_done = ps[0];
      ps = int'(fpu_start);
    end
    fpu_done = 1'b0;
    rsp_ready = '0;
    chk("rr_count", n, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), grants[k], 4'b0001 << (k % 4));
    chk("rr_idle", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
